// File: rtl/nes_bk_pkg.sv
// Shared types and constants for the NES save-state backup sequencer.
// The sector/slot defaults set a 64 x 512B (32KB) slot, with four slots.
package nes_bk_pkg;

   localparam int SECTOR_BITS_DEF = 6;
   localparam int SLOT_BITS_DEF   = 2;
   localparam int SECTORS         = 2 ** SECTOR_BITS_DEF;
   localparam int LBA_W           = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2
   } state_t;

endpackage

// File: rtl/nes_bk_watchdog.sv
// Sector acknowledge watchdog: counts cycles spent waiting on the HPS side
// and flags the cycle that completes 2^W-1 cycles without an ack edge.
module nes_bk_watchdog #(
   parameter int W = 24
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic run,
   output logic expire
);

   localparam logic [W-1:0] MAX  = '1;
   localparam logic [W-1:0] LAST = MAX - W'(1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run && count != MAX) begin
         count <= count + W'(1);
      end
   end

   // Fires as the counter steps onto its maximum, so the owner reacts on that same edge.
   assign expire = run & ~clear & (count == LAST);

endmodule

// File: rtl/nes_bk_sequencer.sv
// Turns OSD load/save level requests into a run of sector reads/writes on the
// hps_io sd_* interface, with slot-based LBA and a NES-reset hold during loads.
module nes_bk_sequencer
   import nes_bk_pkg::*;
#(
   parameter int SECTOR_BITS = SECTOR_BITS_DEF,
   parameter int SLOT_BITS   = SLOT_BITS_DEF,
   parameter int TIMEOUT_W   = 24
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 load_req,
   input  logic                 save_req,
   input  logic [SLOT_BITS-1:0] slot,
   input  logic                 sd_ack,
   output logic [LBA_W-1:0]     sd_lba,
   output logic                 sd_rd,
   output logic                 sd_wr,
   output logic                 busy,
   output logic                 loading,
   output logic                 done,
   output logic                 timeout_err,
   output state_t               dbg_state
);

   // sd_rd/sd_wr is a request held until the first sd_ack rise; the sector is
   // complete on the following sd_ack fall, after which the next request may be raised.

   state_t                 state;
   logic                   old_load;
   logic                   old_save;
   logic                   old_ack;
   logic                   is_load;
   logic                   abort_pend;
   logic [SLOT_BITS-1:0]   slot_q;
   logic [SECTOR_BITS-1:0] sector;
   logic [SECTOR_BITS-1:0] sector_nxt;
   logic                   load_go;
   logic                   save_go;
   logic                   ack_rise;
   logic                   ack_fall;
   logic                   wd_clear;
   logic                   wd_run;
   logic                   wd_expire;

   assign load_go    = load_req & enable & ~old_load;
   assign save_go    = save_req & enable & ~old_save;
   assign ack_rise   = sd_ack & ~old_ack;
   assign ack_fall   = ~sd_ack & old_ack;
   assign sector_nxt = sector + SECTOR_BITS'(1);
   assign wd_run     = (state != IDLE);
   assign wd_clear   = (state == IDLE) | ack_rise | ack_fall;
   assign dbg_state  = state;

   nes_bk_watchdog #(
      .W(TIMEOUT_W)
   ) u_watchdog (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (wd_clear),
      .run    (wd_run),
      .expire (wd_expire)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         old_load    <= 1'b1;
         old_save    <= 1'b1;
         old_ack     <= 1'b1;
         is_load     <= 1'b0;
         abort_pend  <= 1'b0;
         slot_q      <= '0;
         sector      <= '0;
         sd_lba      <= '0;
         sd_rd       <= 1'b0;
         sd_wr       <= 1'b0;
         busy        <= 1'b0;
         loading     <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         old_load <= load_req & enable;
         old_save <= save_req & enable;
         old_ack  <= sd_ack;
         done     <= 1'b0;

         case (state)
            IDLE: begin
               // Load wins when both edges land together; the save edge is dropped.
               if (load_go || save_go) begin
                  slot_q      <= slot;
                  sector      <= '0;
                  is_load     <= load_go;
                  abort_pend  <= 1'b0;
                  sd_lba      <= LBA_W'({slot, {SECTOR_BITS{1'b0}}});
                  sd_rd       <= load_go;
                  sd_wr       <= ~load_go;
                  busy        <= 1'b1;
                  loading     <= load_go;
                  timeout_err <= 1'b0;
                  state       <= REQ;
               end
            end

            REQ: begin
               if (ack_rise) begin
                  sd_rd      <= 1'b0;
                  sd_wr      <= 1'b0;
                  abort_pend <= ~enable;
                  state      <= XFER;
               end else if (!enable || wd_expire) begin
                  sd_rd       <= 1'b0;
                  sd_wr       <= 1'b0;
                  busy        <= 1'b0;
                  loading     <= 1'b0;
                  timeout_err <= enable;
                  state       <= IDLE;
               end
            end

            XFER: begin
               if (ack_fall) begin
                  if (abort_pend || !enable) begin
                     busy    <= 1'b0;
                     loading <= 1'b0;
                     state   <= IDLE;
                  end else if (&sector) begin
                     busy    <= 1'b0;
                     loading <= 1'b0;
                     done    <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     sector <= sector_nxt;
                     sd_lba <= LBA_W'({slot_q, sector_nxt});
                     sd_rd  <= is_load;
                     sd_wr  <= ~is_load;
                     state  <= REQ;
                  end
               end else if (wd_expire) begin
                  busy        <= 1'b0;
                  loading     <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else if (!enable) begin
                  // HPS is mid-sector; let it finish before backing out.
                  abort_pend <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nes_bk_sequencer.sv
// Directed-sequence bench for nes_bk_sequencer with a randomized HPS ack responder
// and a slot/sector LBA reference queue.
module tb_nes_bk_sequencer;

   localparam int TW      = 8;
   localparam int SECTORS = nes_bk_pkg::SECTORS;

   logic                clk;
   logic                reset_n;
   logic                enable;
   logic                load_req;
   logic                save_req;
   logic [1:0]          slot;
   logic                sd_ack;
   logic [31:0]         sd_lba;
   logic                sd_rd;
   logic                sd_wr;
   logic                busy;
   logic                loading;
   logic                done;
   logic                timeout_err;
   nes_bk_pkg::state_t  dbg_state;

   int                  checks;
   int                  failures;
   int                  done_cnt;
   logic [31:0]         exp_q[$];

   nes_bk_sequencer #(
      .SECTOR_BITS(6),
      .SLOT_BITS  (2),
      .TIMEOUT_W  (TW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .load_req   (load_req),
      .save_req   (save_req),
      .slot       (slot),
      .sd_ack     (sd_ack),
      .sd_lba     (sd_lba),
      .sd_rd      (sd_rd),
      .sd_wr      (sd_wr),
      .busy       (busy),
      .loading    (loading),
      .done       (done),
      .timeout_err(timeout_err),
      .dbg_state  (dbg_state)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_time_limit observed=running expected=finished");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (sd_rd === 1'b1 || sd_wr === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   // Plays the HPS side for a transfer from slot s. With n_full < SECTORS it
   // completes n_full sectors and returns with the next request left pending.
   task automatic run_xfer(input bit ld, input int s, input int n_full, input int ack_len_fixed);
      logic [31:0] exp_lba;
      bit          ok;
      int          k;
      exp_q.delete();
      for (int i = 0; i < SECTORS; i++) exp_q.push_back(32'(s * SECTORS + i));
      done_cnt = 0;
      for (int i = 0; i <= n_full && i < SECTORS; i++) begin
         wait_req(ok);
         check("req_seen", 32'(ok), 32'd1);
         if (!ok) return;
         exp_lba = exp_q.pop_front();
         check("lba", sd_lba, exp_lba);
         check("dir", 32'({sd_rd, sd_wr}), ld ? 32'd2 : 32'd1);
         check("loading", 32'(loading), 32'(ld));
         check("busy", 32'(busy), 32'd1);
         if (i == n_full) return;
         slot = 2'($urandom_range(0, 3));
         repeat ($urandom_range(0, 3)) step();
         sd_ack = 1'b1;
         step();
         check("rw_drop", 32'({sd_rd, sd_wr}), 32'd0);
         k = (ack_len_fixed != 0) ? ack_len_fixed : int'($urandom_range(1, 5));
         repeat (k - 1) step();
         sd_ack = 1'b0;
         step();
      end
      check("done_pulse", 32'(done), 32'd1);
      check("busy_end", 32'(busy), 32'd0);
      check("loading_end", 32'(loading), 32'd0);
      check("rw_end", 32'({sd_rd, sd_wr}), 32'd0);
      step();
      check("done_single", 32'(done), 32'd0);
      check("done_count", 32'(done_cnt), 32'd1);
      check("lba_all_used", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int  s;
      int  cnt;
      checks   = 0;
      failures = 0;
      done_cnt = 0;
      reset_n  = 1'b0;
      enable   = 1'b1;
      load_req = 1'b0;
      save_req = 1'b0;
      slot     = 2'd0;
      sd_ack   = 1'b0;
      repeat (3) step();

      // Reset state
      check("rst_rw", 32'({sd_rd, sd_wr}), 32'd0);
      check("rst_busy", 32'({busy, loading, done, timeout_err}), 32'd0);
      check("rst_lba", sd_lba, 32'd0);
      check("rst_state", 32'(dbg_state), 32'(nes_bk_pkg::IDLE));
      reset_n = 1'b1;
      repeat (2) step();

      // 1: save, slot 2, 4-cycle acks
      slot = 2'd2;
      save_req = 1'b1;
      step();
      check("t1_latency_wr", 32'(sd_wr), 32'd1);
      run_xfer(1'b0, 2, SECTORS, 4);
      save_req = 1'b0;
      step();

      // 2: load, slot 0
      slot = 2'd0;
      load_req = 1'b1;
      step();
      check("t2_latency_rd", 32'(sd_rd), 32'd1);
      run_xfer(1'b1, 0, SECTORS, 0);
      load_req = 1'b0;
      step();

      // 3: simultaneous edges, load wins
      slot = 2'd1;
      load_req = 1'b1;
      save_req = 1'b1;
      step();
      run_xfer(1'b1, 1, SECTORS, 0);
      repeat (3) begin
         step();
         check("t3_save_discarded", 32'({busy, sd_wr}), 32'd0);
      end
      load_req = 1'b0;
      save_req = 1'b0;
      step();

      // 4: disabled requests ignored, held request starts on enable rise
      enable = 1'b0;
      repeat (3) begin
         load_req = 1'b1;
         step();
         check("t4_disabled", 32'({sd_rd, sd_wr, busy}), 32'd0);
         load_req = 1'b0;
         step();
      end
      load_req = 1'b1;
      step();
      check("t4_held_disabled", 32'(busy), 32'd0);
      s = int'($urandom_range(0, 3));
      slot = 2'(s);
      enable = 1'b1;
      step();
      check("t4_enable_start", 32'(sd_rd), 32'd1);
      run_xfer(1'b1, s, SECTORS, 0);
      load_req = 1'b0;
      step();

      // enable falling while a request is waiting aborts without done
      save_req = 1'b1;
      step();
      check("abort_req_wr", 32'(sd_wr), 32'd1);
      done_cnt = 0;
      enable = 1'b0;
      step();
      check("abort_rw", 32'({sd_rd, sd_wr}), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_no_timeout", 32'(timeout_err), 32'd0);
      enable = 1'b1;
      save_req = 1'b0;
      step();

      // 5: no ack -> watchdog
      load_req = 1'b1;
      step();
      cnt = 0;
      while (sd_rd === 1'b1 && cnt < 1000) begin
         cnt++;
         step();
      end
      check("t5_rd_cycles", 32'(cnt), 32'((1 << TW) - 1));
      check("t5_timeout_err", 32'(timeout_err), 32'd1);
      check("t5_busy", 32'({busy, loading}), 32'd0);
      load_req = 1'b0;
      s = int'($urandom_range(0, 3));
      slot = 2'(s);
      save_req = 1'b1;
      step();
      check("t5_err_cleared", 32'(timeout_err), 32'd0);
      check("t5_save_started", 32'(sd_wr), 32'd1);
      run_xfer(1'b0, s, SECTORS, 0);
      save_req = 1'b0;
      step();

      // 6: asynchronous reset mid-load, no restart on release
      s = int'($urandom_range(0, 3));
      slot = 2'(s);
      load_req = 1'b1;
      step();
      run_xfer(1'b1, s, 10, 0);
      #2 reset_n = 1'b0;
      #1;
      check("t6_async_rw", 32'({sd_rd, sd_wr}), 32'd0);
      check("t6_async_flags", 32'({busy, loading, done, timeout_err}), 32'd0);
      check("t6_async_lba", sd_lba, 32'd0);
      repeat (2) step();
      reset_n = 1'b1;
      repeat (4) begin
         step();
         check("t6_no_restart", 32'({sd_rd, busy, loading}), 32'd0);
      end
      load_req = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
